// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the writeback arbiter state encoding.
package pipeline_pkg;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned NUM_REGS = 32;

  typedef enum logic [0:0] {
    PRI_P,
    FORCE_L
  } arb_state_e;

  // One-hot select of a register, with r0 never selected.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] addr);
    logic [NUM_REGS-1:0] mask;
    mask = '0;
    if (addr != REG_AW'(REG_ZERO)) begin
      mask[addr] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for outstanding long-latency writebacks.
module regfile_scoreboard
  import pipeline_pkg::*;
#(
  parameter int unsigned AW = REG_AW
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                set_valid_i,
  input  logic [AW-1:0]       set_addr_i,
  input  logic                clr_valid_i,
  input  logic [AW-1:0]       clr_addr_i,
  output logic [NUM_REGS-1:0] busy_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] set_mask, clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_valid_i) begin
      set_mask = reg_onehot(REG_AW'(set_addr_i));
    end
    if (clr_valid_i) begin
      clr_mask = reg_onehot(REG_AW'(clr_addr_i));
    end
    // A reservation in the same cycle as a clear belongs to a newer op, so set wins.
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback (priority)
// and a long-latency return path protected from starvation.
module regfile_wb_arbiter
  import pipeline_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned AW         = REG_AW,
  parameter int unsigned DW         = DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                p_valid,
  output logic                p_ready,
  input  logic [AW-1:0]       p_addr,
  input  logic [DW-1:0]       p_data,
  input  logic                l_valid,
  output logic                l_ready,
  input  logic [AW-1:0]       l_addr,
  input  logic [DW-1:0]       l_data,
  input  logic                rsv_valid,
  input  logic [AW-1:0]       rsv_addr,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                rf_we,
  output logic [AW-1:0]       rf_waddr,
  output logic [DW-1:0]       rf_wdata,
  output logic                l_forced
);

  localparam logic [3:0] StarveMax  = 4'(STARVE_MAX);
  localparam logic [3:0] StarveLast = 4'(STARVE_MAX - 1);

  arb_state_e state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       rf_we_q, rf_we_d;
  logic [AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;

  logic p_xfer, l_xfer, l_blocked;

  assign p_xfer    = p_valid && p_ready;
  assign l_xfer    = l_valid && l_ready;
  assign l_blocked = l_valid && !l_ready;

  // Ready depends only on state and p_valid, keeping the handshake loop-free.
  always_comb begin
    p_ready  = 1'b1;
    l_ready  = !p_valid;
    l_forced = 1'b0;
    state_d  = state_q;
    unique case (state_q)
      PRI_P: begin
        if (l_blocked && (starve_q == StarveLast)) begin
          state_d = FORCE_L;
        end
      end
      FORCE_L: begin
        p_ready  = 1'b0;
        l_ready  = 1'b1;
        l_forced = 1'b1;
        if (l_xfer || !l_valid) begin
          state_d = PRI_P;
        end
      end
      default: state_d = PRI_P;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (l_xfer || !l_valid) begin
      starve_d = '0;
    end else if (l_blocked && (starve_q != StarveMax)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // At most one transfer per cycle; r0 transfers handshake but never write.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (p_xfer) begin
      if (p_addr != AW'(REG_ZERO)) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = p_addr;
        rf_wdata_d = p_data;
      end
    end else if (l_xfer) begin
      if (l_addr != AW'(REG_ZERO)) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = l_addr;
        rf_wdata_d = l_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= PRI_P;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  regfile_scoreboard #(
    .AW (AW)
  ) u_scoreboard (
    .clk_i       (clk),
    .rst_i       (rst),
    .set_valid_i (rsv_valid),
    .set_addr_i  (rsv_addr),
    .clr_valid_i (l_xfer),
    .clr_addr_i  (l_addr),
    .busy_o      (busy_mask)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with STARVE_MAX = 4.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        p_valid, p_ready;
  logic [4:0]  p_addr;
  logic [31:0] p_data;
  logic        l_valid, l_ready;
  logic [4:0]  l_addr;
  logic [31:0] l_data;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic [31:0] busy_mask;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        l_forced;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wb_arbiter #(
    .STARVE_MAX (4),
    .AW         (5),
    .DW         (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .p_valid   (p_valid),
    .p_ready   (p_ready),
    .p_addr    (p_addr),
    .p_data    (p_data),
    .l_valid   (l_valid),
    .l_ready   (l_ready),
    .l_addr    (l_addr),
    .l_data    (l_data),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .busy_mask (busy_mask),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .l_forced  (l_forced)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    p_valid   = 1'b0;
    p_addr    = '0;
    p_data    = '0;
    l_valid   = 1'b0;
    l_addr    = '0;
    l_data    = '0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    n_checks++;
    if (rf_we !== 1'b0 || busy_mask !== 32'h0 || l_forced !== 1'b0 || p_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_init: rf_we=%b busy=%h forced=%b p_ready=%b required 0 0 0 1",
               rf_we, busy_mask, l_forced, p_ready);
    end
    rst = 1'b0;
    // Populate state, then reset mid-cycle.
    rsv_valid = 1'b1; rsv_addr = 5'd4;
    p_valid = 1'b1; p_addr = 5'd3; p_data = 32'h55;
    tick();
    idle_inputs();
    n_checks++;
    if (busy_mask !== 32'h10 || rf_we !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre: busy=%h rf_we=%b required 00000010 1", busy_mask, rf_we);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy_mask !== 32'h0 || rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'h0 ||
        l_forced !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: busy=%h we=%b waddr=%0d wdata=%h forced=%b required all 0",
               busy_mask, rf_we, rf_waddr, rf_wdata, l_forced);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_p_only();
    p_valid = 1'b1; p_addr = 5'd5; p_data = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (p_ready !== 1'b1 || l_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL p_only_ready: p_ready=%b l_ready=%b required 1 0", p_ready, l_ready);
    end
    tick();
    idle_inputs();
    n_checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL p_only_write: we=%b waddr=%0d wdata=%h required 1 5 deadbeef",
               rf_we, rf_waddr, rf_wdata);
    end
    tick();
    n_checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL p_only_hold: we=%b waddr=%0d wdata=%h required 0 5 deadbeef",
               rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] exp_data;
    l_valid = 1'b1; l_addr = 5'd2; l_data = 32'h0000AAAA;
    p_valid = 1'b1; p_addr = 5'd1;
    for (int c = 1; c <= 6; c++) begin
      p_data = 32'h100 + 32'((c > 5) ? 5 : c);
      if (c == 6) l_valid = 1'b0;
      #1;
      n_checks++;
      if (c == 5) begin
        if (p_ready !== 1'b0 || l_ready !== 1'b1 || l_forced !== 1'b1) begin
          n_fail++;
          $display("FAIL conflict_force c=%0d: p_ready=%b l_ready=%b forced=%b required 0 1 1",
                   c, p_ready, l_ready, l_forced);
        end
      end else begin
        if (p_ready !== 1'b1 || l_ready !== 1'b0 || l_forced !== 1'b0) begin
          n_fail++;
          $display("FAIL conflict_pri c=%0d: p_ready=%b l_ready=%b forced=%b required 1 0 0",
                   c, p_ready, l_ready, l_forced);
        end
      end
      tick();
      n_checks++;
      if (c == 5) begin
        if (rf_we !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'h0000AAAA) begin
          n_fail++;
          $display("FAIL conflict_lwrite: we=%b waddr=%0d wdata=%h required 1 2 0000aaaa",
                   rf_we, rf_waddr, rf_wdata);
        end
      end else begin
        exp_data = 32'h100 + 32'((c > 5) ? 5 : c);
        if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== exp_data) begin
          n_fail++;
          $display("FAIL conflict_pwrite c=%0d: we=%b waddr=%0d wdata=%h required 1 1 %h",
                   c, rf_we, rf_waddr, rf_wdata, exp_data);
        end
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_l_idle_slot();
    l_valid = 1'b1; l_addr = 5'd9; l_data = 32'h1234;
    #1;
    n_checks++;
    if (l_ready !== 1'b1 || l_forced !== 1'b0) begin
      n_fail++;
      $display("FAIL l_idle_ready: l_ready=%b forced=%b required 1 0", l_ready, l_forced);
    end
    tick();
    idle_inputs();
    n_checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h1234) begin
      n_fail++;
      $display("FAIL l_idle_write: we=%b waddr=%0d wdata=%h required 1 9 00001234",
               rf_we, rf_waddr, rf_wdata);
    end
    // Counter must have stayed 0: three blocked cycles must not force L yet.
    p_valid = 1'b1; p_addr = 5'd6; p_data = 32'h6;
    l_valid = 1'b1; l_addr = 5'd10; l_data = 32'hA;
    tick();
    tick();
    tick();
    #1;
    n_checks++;
    if (l_forced !== 1'b0 || p_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL l_idle_counter: forced=%b p_ready=%b required 0 1", l_forced, p_ready);
    end
    p_valid = 1'b0;
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_scoreboard();
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    tick();
    n_checks++;
    if (busy_mask !== 32'h00000080) begin
      n_fail++;
      $display("FAIL sb_reserve: busy=%h required 00000080", busy_mask);
    end
    l_valid = 1'b1; l_addr = 5'd7; l_data = 32'h77;
    tick();
    n_checks++;
    if (busy_mask !== 32'h00000080) begin
      n_fail++;
      $display("FAIL sb_set_wins: busy=%h required 00000080", busy_mask);
    end
    rsv_valid = 1'b0;
    tick();
    idle_inputs();
    n_checks++;
    if (busy_mask !== 32'h00000000) begin
      n_fail++;
      $display("FAIL sb_clear: busy=%h required 00000000", busy_mask);
    end
    // P write to a busy register must leave the mask alone.
    rsv_valid = 1'b1; rsv_addr = 5'd12;
    tick();
    rsv_valid = 1'b0;
    p_valid = 1'b1; p_addr = 5'd12; p_data = 32'hC;
    tick();
    idle_inputs();
    n_checks++;
    if (busy_mask !== 32'h00001000) begin
      n_fail++;
      $display("FAIL sb_p_untouched: busy=%h required 00001000", busy_mask);
    end
    l_valid = 1'b1; l_addr = 5'd12;
    tick();
    idle_inputs();
  endtask

  task automatic test_r0();
    p_valid = 1'b1; p_addr = 5'd0; p_data = 32'hFFFFFFFF;
    #1;
    n_checks++;
    if (p_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL r0_ready: p_ready=%b required 1", p_ready);
    end
    tick();
    idle_inputs();
    n_checks++;
    if (rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL r0_no_write: rf_we=%b required 0", rf_we);
    end
    rsv_valid = 1'b1; rsv_addr = 5'd3;
    tick();
    rsv_addr = 5'd0;
    tick();
    idle_inputs();
    n_checks++;
    if (busy_mask !== 32'h00000008) begin
      n_fail++;
      $display("FAIL r0_reserve: busy=%h required 00000008", busy_mask);
    end
  endtask

  initial begin
    test_reset();
    test_p_only();
    test_conflict();
    test_l_idle_slot();
    test_scoreboard();
    test_r0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
